// File: rtl/demux_lane_collector.sv
// Collects the bits routed by a 1-to-4 demux into per-lane LSB-first words and
// queues completed {lane, word} pairs in a fall-through FIFO with sticky error flags.
module demux_lane_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               s,
  input  logic [3:0]               y,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_lane,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     protocol_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = WIDTH + 2;

  logic [3:0][WIDTH-1:0]   sr_q, sr_d;
  logic [3:0][CW-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    proto_q, proto_d;

  logic                    bit_in;
  logic                    complete;
  logic                    push;
  logic                    pop;
  logic [WIDTH-1:0]        word;
  logic [EW-1:0]           head;

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    proto_d    = proto_q;
    bit_in     = y[s];
    complete   = 1'b0;
    word       = '0;
    pop        = (level_q != '0) && out_ready;

    // Only the selected output may be high while enabled; nothing may be high otherwise.
    if (en) begin
      proto_d = proto_q | (|(y & ~(4'b0001 << s)));
    end else begin
      proto_d = proto_q | (|y);
    end

    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      word = {bit_in, sr_q[s][WIDTH-1:1]};
      if (cnt_q[s] == CW'(WIDTH - 1)) begin
        complete = 1'b1;
        sr_d[s]  = '0;
        cnt_d[s] = '0;
      end else begin
        sr_d[s]  = word;
        cnt_d[s] = cnt_q[s] + CW'(1);
      end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = complete && ((level_q != LW'(DEPTH)) || pop);
    if (complete && !push) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = {s, word};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      proto_q    <= proto_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_valid    = (level_q != '0);
  assign out_lane     = out_valid ? head[EW-1:WIDTH] : 2'b00;
  assign out_data     = out_valid ? head[WIDTH-1:0] : '0;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign protocol_err = proto_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Directed bench for demux_lane_collector: a queue-based reference model checked
// every cycle, plus literal expectations for the planned scenarios.
module tb_demux_lane_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       s = 2'b00;
  logic [3:0]       y = 4'b0000;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [1:0]       out_lane;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       fifo_level;
  logic             overflow;
  logic             protocol_err;

  demux_lane_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .s(s),
    .y(y),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane(out_lane),
    .out_data(out_data),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: lane words built arithmetically, FIFO as a queue.
  logic [WIDTH+1:0] m_q[$];
  int               m_word[4];
  int               m_cnt[4];
  bit               m_ovf = 1'b0;
  bit               m_proto = 1'b0;
  bit               started = 1'b0;
  bit               m_pop, m_full, m_done;
  int               m_l, m_b;
  logic [WIDTH+1:0] m_entry;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_word[i] = 0;
        m_cnt[i]  = 0;
      end
      m_ovf   = 1'b0;
      m_proto = 1'b0;
      started = 1'b1;
    end else begin
      m_pop  = (m_q.size() > 0) && out_ready;
      m_full = (m_q.size() == DEPTH);
      m_done = 1'b0;
      if (en) begin
        if ((y & ~(4'b0001 << s)) != 4'b0000) m_proto = 1'b1;
      end else if (y != 4'b0000) begin
        m_proto = 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < 4; i++) begin
          m_word[i] = 0;
          m_cnt[i]  = 0;
        end
      end else if (en) begin
        m_l = int'(s);
        m_b = int'(y[s]);
        m_word[m_l] = m_word[m_l] + (m_b << m_cnt[m_l]);
        m_cnt[m_l]  = m_cnt[m_l] + 1;
        if (m_cnt[m_l] == WIDTH) begin
          m_done      = 1'b1;
          m_entry     = {s, WIDTH'(m_word[m_l])};
          m_word[m_l] = 0;
          m_cnt[m_l]  = 0;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_done) begin
        if (m_full && !m_pop) m_ovf = 1'b1;
        else m_q.push_back(m_entry);
      end
    end
  end

  logic [1:0]       e_lane;
  logic [WIDTH-1:0] e_data;

  always @(negedge clk) begin
    if (started) begin
      e_lane = 2'b00;
      e_data = '0;
      if (m_q.size() > 0) begin
        e_lane = m_q[0][WIDTH+1:WIDTH];
        e_data = m_q[0][WIDTH-1:0];
      end
      checkOutput("model out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      checkOutput("model fifo_level", 32'(fifo_level), 32'(m_q.size()));
      checkOutput("model out_lane", 32'(out_lane), 32'(e_lane));
      checkOutput("model out_data", 32'(out_data), 32'(e_data));
      checkOutput("model overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("model protocol_err", 32'(protocol_err), 32'(m_proto));
    end
  end

  task automatic applyStimulus(input logic e, input logic [1:0] sel, input logic [3:0] yy,
                               input logic fl, input logic rdy);
    en        = e;
    s         = sel;
    y         = yy;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, rdy);
  endtask

  task automatic feedBit(input logic [1:0] lane, input logic b, input logic rdy);
    applyStimulus(1'b1, lane, 4'(b) << lane, 1'b0, rdy);
  endtask

  task automatic feedWord(input logic [1:0] lane, input logic [WIDTH-1:0] value, input logic rdy);
    for (int i = 0; i < WIDTH; i++) feedBit(lane, value[i], rdy);
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [1:0] lane,
                           input logic [WIDTH-1:0] data, input logic [2:0] level);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, " out_lane"}, 32'(out_lane), 32'(lane));
    checkOutput({tag, " out_data"}, 32'(out_data), 32'(data));
    checkOutput({tag, " fifo_level"}, 32'(fifo_level), 32'(level));
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    checkHead("reset", 1'b0, 2'd0, 8'h00, 3'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset protocol_err", 32'(protocol_err), 32'd0);

    // Lane 2 receives 1,0,1,1,0,0,1,0 LSB-first.
    feedWord(2'd2, 8'h4D, 1'b1);
    checkHead("lane2 word", 1'b1, 2'd2, 8'h4D, 3'd1);
    idle(1'b1);
    checkHead("lane2 popped", 1'b0, 2'd0, 8'h00, 3'd0);

    // Interleave lane 0 (ones) and lane 1 (zeros).
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) feedBit(2'd0, 1'b1, 1'b1);
      else feedBit(2'd1, 1'b0, 1'b1);
    end
    checkHead("interleave lane0", 1'b1, 2'd0, 8'hFF, 3'd1);
    feedBit(2'd1, 1'b0, 1'b1);
    checkHead("interleave lane1", 1'b1, 2'd1, 8'h00, 3'd1);
    idle(1'b1);
    checkOutput("interleave overflow", 32'(overflow), 32'd0);
    checkOutput("interleave protocol_err", 32'(protocol_err), 32'd0);

    // Fill the FIFO on lane 3 and overflow it with a fifth word.
    for (int k = 1; k <= 4; k++) feedWord(2'd3, 8'(k), 1'b0);
    checkOutput("fill level", 32'(fifo_level), 32'd4);
    checkOutput("fill overflow", 32'(overflow), 32'd0);
    feedWord(2'd3, 8'h05, 1'b0);
    checkOutput("overflow level", 32'(fifo_level), 32'd4);
    checkOutput("overflow flag", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      checkHead("drain", 1'b1, 2'd3, 8'(k), 3'(5 - k));
      idle(1'b1);
    end
    checkHead("drained", 1'b0, 2'd0, 8'h00, 3'd0);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);

    // Partial lane 1 word is flushed; the flush-cycle bit is discarded too.
    for (int i = 0; i < 3; i++) feedBit(2'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd1, 4'b0000, 1'b1, 1'b1);
    checkOutput("flush no word", 32'(fifo_level), 32'd0);
    feedWord(2'd1, 8'hFF, 1'b1);
    checkHead("after flush", 1'b1, 2'd1, 8'hFF, 3'd1);
    idle(1'b1);

    // Stray y while disabled, then an extra high bit while enabled.
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b0, 1'b1);
    checkOutput("proto en0", 32'(protocol_err), 32'd1);
    applyStimulus(1'b1, 2'd0, 4'b0011, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) feedBit(2'd0, 1'b0, 1'b1);
    checkOutput("proto partial", 32'(fifo_level), 32'd0);
    feedBit(2'd0, 1'b0, 1'b1);
    checkHead("proto word", 1'b1, 2'd0, 8'h01, 3'd1);
    idle(1'b1);

    // Reset in the middle of activity.
    feedWord(2'd2, 8'hA5, 1'b0);
    feedWord(2'd2, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) feedBit(2'd0, 1'b1, 1'b0);
    checkHead("pre-reset", 1'b1, 2'd2, 8'hA5, 3'd2);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b0011, 1'b0, 1'b0);
    rst = 1'b0;
    checkHead("mid reset", 1'b0, 2'd0, 8'h00, 3'd0);
    checkOutput("mid reset overflow", 32'(overflow), 32'd0);
    checkOutput("mid reset protocol_err", 32'(protocol_err), 32'd0);
    for (int i = 0; i < 7; i++) feedBit(2'd0, (i == 1 || i == 2 || i == 4) ? 1'b1 : 1'b0, 1'b1);
    checkOutput("post reset partial", 32'(fifo_level), 32'd0);
    feedBit(2'd0, 1'b1, 1'b1);
    checkHead("post reset word", 1'b1, 2'd0, 8'h96, 3'd1);
    idle(1'b1);
    checkHead("post reset drained", 1'b0, 2'd0, 8'h00, 3'd0);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/demux_lane_collector.md
Name: demux_lane_collector

Overview:
- Downstream consumer of the 1-to-4 single-bit demultiplexer stage.
- Watches the demux enable, select and 4-bit output each clock, and accumulates the bit routed to each lane into a per-lane WIDTH-bit word.
- When a lane's word is complete, pushes {lane, word} into a small first-word-fall-through FIFO, drained through a valid/ready handshake.
- Flags protocol violations on the demux outputs and FIFO overflow.

Parameters:
- WIDTH, 8, bits per assembled lane word (>=2).
- DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  demux enable; 1 = a bit is routed this cycle.
- s  in  2  demux lane select.
- y  in  4  demux outputs; routed bit is y[s].
- flush  in  1  synchronous clear of all partial lane words.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_lane  out  2  lane of head word.
- out_data  out  WIDTH  head word.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a completed word was dropped.
- protocol_err  out  1  sticky: illegal demux output pattern seen.

Behaviour:
- Reset (rst=1 at edge), all zeroed:
  - lane shift registers and lane bit counters;
  - FIFO pointers, fifo_level, out_valid;
  - overflow, protocol_err.
  - out_lane and out_data read 0 while the FIFO is empty.
- Reset mid-operation discards partial words and all FIFO contents. It has priority over every other input.
- Bit capture, when en=1 and flush=0:
  - b = y[s].
  - Lane s shift register shifts right with b entering bit WIDTH-1.
  - The lane s counter increments.
  - Word bit k = k-th bit received (k=0 first), i.e. LSB-first assembly.
  - Other lanes are unchanged.
  - At most one lane advances per cycle.
- en=0: no lane state changes.
- Completion:
  - When the lane s counter is WIDTH-1 and a bit is captured, the assembled word (including b) is offered to the FIFO at that same edge.
  - The counter wraps to 0 and the shift register clears.
  - Latency: out_valid rises in the cycle after the edge sampling the final bit, if the FIFO was empty.
- FIFO:
  - Push on completion; pop when out_valid && out_ready.
  - Order is strictly completion order across lanes.
  - Push and pop in the same cycle are both honoured and fifo_level is unchanged. This is legal when full (pop frees the slot) and when empty with a push (no pop, since out_valid=0 that cycle).
  - Head is fall-through: out_lane/out_data hold the head entry while out_valid=1, and are stable until popped.
- Overflow:
  - A completion while fifo_level=DEPTH and no same-cycle pop drops the word; the lane counter still wraps to 0.
  - overflow is set and stays 1 until rst.
- protocol_err is set (sticky until rst) when either:
  - en=1 and any y bit other than y[s] is 1; or
  - en=0 and y != 0.
  - The capture still uses y[s] when en=1.
- flush=1:
  - Clears all lane shift registers and counters.
  - Any bit presented that cycle is discarded and no completion occurs.
  - FIFO contents and sticky flags are untouched; a pop in that cycle is still honoured.
- The lane counter is clog2(WIDTH)+1 bits and never exceeds WIDTH-1 after update.

Test Plan:
- WIDTH=8, DEPTH=4, out_ready=1, en=1, s=2, bits 1,0,1,1,0,0,1,0 (y=b<<2) -> next cycle out_valid=1, out_lane=2, out_data=8'h4D, fifo_level=1; popped the following edge.
- 16 cycles alternating s=0 (b=1) and s=1 (b=0), starting with lane 0 -> lane 0 word 8'hFF appears first, then lane 1 8'h00 one cycle later; no flags.
- out_ready=0, complete 5 words on lane 3 (values 8'h01..8'h05) -> fifo_level=4, fifo_level unchanged at fifth completion, overflow=1; then out_ready=1 drains 8'h01..8'h04 in order, lane 3 each.
- Lane 1 fed 3 bits, then flush=1 with en=1, then 8 bits of 1 -> single word 8'hFF; flush-cycle bit absent; fifo_level=1.
- en=0 with y=4'b0001; then en=1, s=0, y=4'b0011 -> protocol_err=1 after first case; lane 0 counter advances only on second (bit 1).
- FIFO holding 2 words, lane 0 at 5 bits, rst=1 one cycle -> next cycle out_valid=0, fifo_level=0, overflow=0, protocol_err=0; a new 8-bit lane 0 sequence yields exactly one word.
